// File: rtl/alu_cmd_sequencer.sv
// Queues {func, operand} commands and runs each against the accumulator through the external mapper/ALU.
// done_o rises ALU_LAT+2 edges after the push edge; cmd_ready_o is low while the FIFO is full or rst_i is high.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_f_i,
  input  logic [7:0] cmd_b_i,
  output logic       f0_o,
  output logic       f1_o,
  output logic       f2_o,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  input  logic [7:0] alu_y_i,
  input  logic       alu_cout_i,
  input  logic       acc_clr_i,
  output logic [7:0] acc_o,
  output logic       acc_c_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] err_count_o,
  output logic       busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = 4;

  typedef struct packed {
    logic [2:0] f;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [2:0]    op_f_q;
  logic [7:0]    op_b_q;
  logic [7:0]    acc_q;
  logic          acc_c_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    err_count_q;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          undef_op;
  logic          arith_op;

  assign fifo_empty  = (count_q == '0);
  assign cmd_ready_o = !rst_i && (count_q < CW'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;
  assign undef_op    = (op_f_q == 3'b000);
  // ADD/SUB/INC/DEC keep the ALU carry; logic ops always clear it
  assign arith_op    = (op_f_q >= 3'b001) && (op_f_q <= 3'b100);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (undef_op) begin
          state_d = S_IDLE;
        end else if (ALU_LAT == 1) begin
          state_d = S_WB;
        end else begin
          state_d = S_WAIT;
          lat_d   = LW'(ALU_LAT - 1);
        end
      end
      S_WAIT: begin
        lat_d = lat_q - LW'(1);
        if (lat_q == LW'(1)) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{f: cmd_f_i, b: cmd_b_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      lat_q       <= '0;
      op_f_q      <= '0;
      op_b_q      <= '0;
      acc_q       <= '0;
      acc_c_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        op_f_q   <= mem_q[rd_ptr_q].f;
        op_b_q   <= mem_q[rd_ptr_q].b;
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      // a clear in the WB cycle takes precedence over the write-back
      if (acc_clr_i) begin
        acc_q   <= '0;
        acc_c_q <= 1'b0;
      end else if (state_q == S_WB) begin
        acc_q   <= alu_y_i;
        acc_c_q <= arith_op ? alu_cout_i : 1'b0;
      end
      done_q <= (state_q == S_WB);
      err_q  <= (state_q == S_ISSUE) && undef_op;
      if ((state_q == S_ISSUE) && undef_op && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign f0_o        = op_f_q[0];
  assign f1_o        = op_f_q[1];
  assign f2_o        = op_f_q[2];
  assign alu_a_o     = acc_q;
  assign alu_b_o     = op_b_q;
  assign acc_o       = acc_q;
  assign acc_c_o     = acc_c_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_count_o = err_count_q;
  assign busy_o      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: one instance with ALU_LAT=1 and one with ALU_LAT=4, each with its own ALU model.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] f;
    logic [7:0] b;
    logic [7:0] exp_acc;
    logic       exp_c;
  } vec_t;

  vec_t va [7];
  vec_t vb [8];

  logic       rst1, cmd_valid1, cmd_ready1, f0_1, f1_1, f2_1, alu_cout1, acc_clr1;
  logic       acc_c1, done1, err1, busy1;
  logic [2:0] cmd_f1;
  logic [7:0] cmd_b1, alu_a1, alu_b1, alu_y1, acc1, err_count1;

  logic       rst4, cmd_valid4, cmd_ready4, f0_4, f1_4, f2_4, alu_cout4, acc_clr4;
  logic       acc_c4, done4, err4, busy4;
  logic [2:0] cmd_f4;
  logic [7:0] cmd_b4, alu_a4, alu_b4, alu_y4, acc4, err_count4;

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1)) u1 (
    .clk_i(clk), .rst_i(rst1), .cmd_valid_i(cmd_valid1), .cmd_ready_o(cmd_ready1),
    .cmd_f_i(cmd_f1), .cmd_b_i(cmd_b1), .f0_o(f0_1), .f1_o(f1_1), .f2_o(f2_1),
    .alu_a_o(alu_a1), .alu_b_o(alu_b1), .alu_y_i(alu_y1), .alu_cout_i(alu_cout1),
    .acc_clr_i(acc_clr1), .acc_o(acc1), .acc_c_o(acc_c1), .done_o(done1), .err_o(err1),
    .err_count_o(err_count1), .busy_o(busy1)
  );

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(4)) u4 (
    .clk_i(clk), .rst_i(rst4), .cmd_valid_i(cmd_valid4), .cmd_ready_o(cmd_ready4),
    .cmd_f_i(cmd_f4), .cmd_b_i(cmd_b4), .f0_o(f0_4), .f1_o(f1_4), .f2_o(f2_4),
    .alu_a_o(alu_a4), .alu_b_o(alu_b4), .alu_y_i(alu_y4), .alu_cout_i(alu_cout4),
    .acc_clr_i(acc_clr4), .acc_o(acc4), .acc_c_o(acc_c4), .done_o(done4), .err_o(err4),
    .err_count_o(err_count4), .busy_o(busy4)
  );

  // Carry out of the logic ops is driven high so the sequencer must mask it
  function automatic logic [8:0] alu_fn(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = 9'h000;
    case (f)
      3'b001:  r = {1'b0, a} + {1'b0, b};
      3'b010:  r = {1'b0, a} - {1'b0, b};
      3'b011:  r = {1'b0, a} + 9'd1;
      3'b100:  r = {1'b0, a} - 9'd1;
      3'b101:  r = {1'b1, a & b};
      3'b110:  r = {1'b1, a ^ b};
      3'b111:  r = {1'b1, ~a};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  always @(posedge clk) {alu_cout1, alu_y1} <= alu_fn({f2_1, f1_1, f0_1}, alu_a1, alu_b1);

  logic [8:0] p4 [4];
  always @(posedge clk) begin
    p4[0] <= alu_fn({f2_4, f1_4, f0_4}, alu_a4, alu_b4);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign {alu_cout4, alu_y4} = p4[3];

  logic [8:0] res1 [$];
  logic [8:0] res4 [$];
  int err_pulses1 = 0, err_pulses4 = 0, both1 = 0, both4 = 0;
  logic [7:0] err_acc1 = 8'h00;

  always @(negedge clk) begin
    if (done1) res1.push_back({acc_c1, acc1});
    if (done4) res4.push_back({acc_c4, acc4});
    if (err1) begin
      err_pulses1++;
      err_acc1 = acc1;
    end
    if (err4) err_pulses4++;
    if (done1 && err1) both1++;
    if (done4 && err4) both4++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int u, input logic [2:0] f, input logic [7:0] b);
    int n = 0;
    if (u == 1) begin
      cmd_valid1 = 1'b1; cmd_f1 = f; cmd_b1 = b;
      while (!cmd_ready1 && n < 200) begin @(negedge clk); n++; end
    end else begin
      cmd_valid4 = 1'b1; cmd_f4 = f; cmd_b4 = b;
      while (!cmd_ready4 && n < 200) begin @(negedge clk); n++; end
    end
    if (n >= 200) chk("push_timeout", 32'(n), 32'(0));
    @(negedge clk);
    cmd_valid1 = 1'b0;
    cmd_valid4 = 1'b0;
  endtask

  task automatic wait_res(input int u, input int cnt);
    int k = 0;
    while (((u == 1) ? res1.size() : res4.size()) < cnt && k < 500) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("result_count", 32'((u == 1) ? res1.size() : res4.size()), 32'(cnt));
  endtask

  task automatic wait_idle(input int u);
    int k = 0;
    while (((u == 1) ? busy1 : busy4) && k < 2000) begin @(negedge clk); k++; end
    chk("idle_reached", 32'((u == 1) ? busy1 : busy4), 32'(0));
  endtask

  initial begin
    int idx, n;
    logic will_push;
    va[0] = '{3'b001, 8'hF0, 8'hF0, 1'b0};
    va[1] = '{3'b001, 8'h20, 8'h10, 1'b1};
    va[2] = '{3'b010, 8'h01, 8'h0F, 1'b0};
    va[3] = '{3'b011, 8'h00, 8'h10, 1'b0};
    va[4] = '{3'b100, 8'h00, 8'h0F, 1'b0};
    va[5] = '{3'b110, 8'hFF, 8'hF0, 1'b0};
    va[6] = '{3'b111, 8'h00, 8'h0F, 1'b0};
    vb[0] = '{3'b001, 8'h01, 8'h01, 1'b0};
    vb[1] = '{3'b001, 8'h02, 8'h03, 1'b0};
    vb[2] = '{3'b001, 8'h04, 8'h07, 1'b0};
    vb[3] = '{3'b001, 8'h08, 8'h0F, 1'b0};
    vb[4] = '{3'b001, 8'h10, 8'h1F, 1'b0};
    vb[5] = '{3'b010, 8'h01, 8'h1E, 1'b0};
    vb[6] = '{3'b110, 8'h0F, 8'h11, 1'b0};
    vb[7] = '{3'b011, 8'h00, 8'h12, 1'b0};

    rst1 = 1'b1; cmd_valid1 = 1'b0; cmd_f1 = 3'b000; cmd_b1 = 8'h00; acc_clr1 = 1'b0;
    rst4 = 1'b1; cmd_valid4 = 1'b0; cmd_f4 = 3'b000; cmd_b4 = 8'h00; acc_clr4 = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ready", 32'(cmd_ready1), 32'(0));
    chk("rst_acc", 32'(acc1), 32'(0));
    chk("rst_acc_c", 32'(acc_c1), 32'(0));
    chk("rst_done_err", 32'({done1, err1}), 32'(0));
    chk("rst_err_count", 32'(err_count1), 32'(0));
    chk("rst_busy", 32'(busy1), 32'(0));
    chk("rst_func", 32'({f2_1, f1_1, f0_1}), 32'(0));
    chk("rst_alu_b", 32'(alu_b1), 32'(0));
    rst1 = 1'b0; rst4 = 1'b0;
    #1;
    chk("ready_after_rst", 32'({cmd_ready1, cmd_ready4}), 32'(3));
    @(negedge clk);

    // single ADD: done only in the 4th cycle after the push cycle
    push(1, 3'b001, 8'h05);
    for (int i = 0; i < 4; i++) begin
      chk("add5_done_timing", 32'(done1), 32'(i == 3));
      if (i < 3) @(negedge clk);
    end
    chk("add5_acc", 32'({acc_c1, acc1}), 32'(9'h005));
    chk("add5_busy", 32'(busy1), 32'(0));
    @(negedge clk);
    chk("add5_done_once", 32'(done1), 32'(0));

    acc_clr1 = 1'b1;
    @(negedge clk);
    acc_clr1 = 1'b0;
    chk("acc_clr_idle", 32'(acc1), 32'(0));
    res1.delete();

    for (int i = 0; i < 7; i++) push(1, va[i].f, va[i].b);
    wait_res(1, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("seq_a[%0d]", i), 32'(res1[i]), 32'({va[i].exp_c, va[i].exp_acc}));

    // undefined op between INC and ADD
    res1.delete();
    push(1, 3'b011, 8'h00);
    wait_res(1, 1);
    res1.delete();
    err_pulses1 = 0;
    push(1, 3'b000, 8'h00);
    push(1, 3'b001, 8'h03);
    wait_res(1, 1);
    chk("undef_err_pulses", 32'(err_pulses1), 32'(1));
    chk("undef_err_count", 32'(err_count1), 32'(1));
    chk("undef_acc_kept", 32'(err_acc1), 32'(8'h10));
    chk("undef_then_add", 32'(res1[0]), 32'(9'h013));
    for (int i = 0; i < 256; i++) push(1, 3'b000, 8'hAA);
    wait_idle(1);
    repeat (2) @(negedge clk);
    chk("err_count_sat", 32'(err_count1), 32'(255));
    chk("err_pulses_total", 32'(err_pulses1), 32'(257));
    chk("err_acc_unchanged", 32'(acc1), 32'(8'h13));

    // clear during the WB cycle of ADD 0x07
    res1.delete();
    push(1, 3'b001, 8'h07);
    push(1, 3'b001, 8'h02);
    @(negedge clk);
    acc_clr1 = 1'b1;
    @(negedge clk);
    acc_clr1 = 1'b0;
    wait_res(1, 2);
    chk("clr_wb_result", 32'(res1[0]), 32'(9'h000));
    chk("clr_next_add", 32'(res1[1]), 32'(9'h002));

    // ALU_LAT=4: valid held high through backpressure
    idx = 0; n = 0;
    cmd_valid4 = 1'b1;
    while (idx < 8 && n < 400) begin
      cmd_f4 = vb[idx].f; cmd_b4 = vb[idx].b;
      will_push = cmd_ready4;
      @(negedge clk);
      n++;
      if (will_push) begin
        idx++;
        if (idx == 5) chk("full_ready_low", 32'(cmd_ready4), 32'(0));
      end
    end
    cmd_valid4 = 1'b0;
    chk("lat4_all_pushed", 32'(idx), 32'(8));
    wait_res(4, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("seq_b[%0d]", i), 32'(res4[i]), 32'({vb[i].exp_c, vb[i].exp_acc}));

    // reset while the head op waits on the ALU with three entries queued
    wait_idle(4);
    for (int i = 0; i < 4; i++) push(4, 3'b001, 8'h01);
    res4.delete();
    err_pulses4 = 0;
    rst4 = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(cmd_ready4), 32'(0));
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    chk("mid_rst_ready_after", 32'(cmd_ready4), 32'(1));
    chk("mid_rst_busy", 32'(busy4), 32'(0));
    chk("mid_rst_acc", 32'({acc_c4, acc4}), 32'(0));
    repeat (20) @(negedge clk);
    chk("mid_rst_no_done", 32'(res4.size()), 32'(0));
    chk("mid_rst_no_err", 32'(err_pulses4), 32'(0));
    push(4, 3'b001, 8'h05);
    wait_res(4, 1);
    chk("post_rst_add", 32'(res4[0]), 32'(9'h005));
    repeat (20) @(negedge clk);
    chk("post_rst_fifo_empty", 32'(res4.size()), 32'(1));

    chk("done_err_exclusive", 32'(both1 + both4), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
